// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle EX holds, plus saturating stall/flush performance counters.
module hazard_control_unit #(
    parameter int MC_LATENCY  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   ID_EX_MemRead,
    input  logic [4:0]             ID_EX_RegisterRt,
    input  logic [4:0]             IF_ID_RegisterRs,
    input  logic [4:0]             IF_ID_RegisterRt,
    input  logic                   IF_ID_UsesRt,
    input  logic                   BranchTaken,
    input  logic                   MCStart,
    output logic [1:0]             IF_ID_Signal,
    output logic                   PCWrite,
    output logic                   ID_EX_Flush,
    output logic                   EX_Hold,
    output logic                   MCBusy,
    output logic [COUNT_WIDTH-1:0] StallCycles,
    output logic [COUNT_WIDTH-1:0] FlushCount
);

    localparam logic [1:0] SIG_ADVANCE = 2'd0;
    localparam logic [1:0] SIG_STALL   = 2'd1;
    localparam logic [1:0] SIG_FLUSH   = 2'd2;

    // The MCStart cycle is the first stall cycle, so MC_BUSY lasts MC_LATENCY-2 cycles.
    localparam logic [7:0] CNT_LOAD    = 8'(MC_LATENCY - 2);
    localparam bit         NEEDS_BUSY  = (MC_LATENCY > 2);

    typedef enum logic {RUN, MC_BUSY} state_t;

    state_t                 state_reg, state_next;
    logic [7:0]             cnt_reg, cnt_next;
    logic [COUNT_WIDTH-1:0] stall_cycles_reg, flush_count_reg;
    logic                   load_use;

    assign load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                      ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                       (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= RUN;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (!BranchTaken && MCStart) begin
                    cnt_next   = CNT_LOAD;
                    state_next = NEEDS_BUSY ? MC_BUSY : RUN;
                end
            end
            MC_BUSY: begin
                if (cnt_reg == 8'd1) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        IF_ID_Signal = SIG_ADVANCE;
        PCWrite      = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_Hold      = 1'b0;
        MCBusy       = 1'b0;
        if (!Reset_n) begin
            // Hold the pipeline empty for as long as reset is asserted.
            IF_ID_Signal = SIG_FLUSH;
            PCWrite      = 1'b0;
            ID_EX_Flush  = 1'b1;
        end else if (state_reg == MC_BUSY) begin
            IF_ID_Signal = SIG_STALL;
            PCWrite      = 1'b0;
            EX_Hold      = 1'b1;
            MCBusy       = 1'b1;
        end else if (BranchTaken) begin
            IF_ID_Signal = SIG_FLUSH;
            ID_EX_Flush  = 1'b1;
        end else if (MCStart) begin
            IF_ID_Signal = SIG_STALL;
            PCWrite      = 1'b0;
            EX_Hold      = 1'b1;
        end else if (load_use) begin
            IF_ID_Signal = SIG_STALL;
            PCWrite      = 1'b0;
            ID_EX_Flush  = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if ((IF_ID_Signal == SIG_STALL) && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
            if ((IF_ID_Signal == SIG_FLUSH) && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    assign StallCycles = stall_cycles_reg;
    assign FlushCount  = flush_count_reg;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (latency 4 / 4-bit counters and
// latency 2 / 16-bit counters) compared every cycle against a behavioural model.
module tb_hazard_control_unit;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_RegisterRt;
    logic [4:0] IF_ID_RegisterRs;
    logic [4:0] IF_ID_RegisterRt;
    logic       IF_ID_UsesRt;
    logic       BranchTaken;
    logic       MCStart;

    logic [1:0]  sig_o [2];
    logic        pcw_o [2];
    logic        flush_o [2];
    logic        hold_o [2];
    logic        busy_o [2];
    logic [3:0]  stall0, flushc0;
    logic [15:0] stall1, flushc1;

    always #5 Clock = ~Clock;

    hazard_control_unit #(.MC_LATENCY(4), .COUNT_WIDTH(4)) dut0 (
        .Clock(Clock), .Reset_n(Reset_n),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegisterRt(ID_EX_RegisterRt),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .IF_ID_UsesRt(IF_ID_UsesRt), .BranchTaken(BranchTaken), .MCStart(MCStart),
        .IF_ID_Signal(sig_o[0]), .PCWrite(pcw_o[0]), .ID_EX_Flush(flush_o[0]),
        .EX_Hold(hold_o[0]), .MCBusy(busy_o[0]),
        .StallCycles(stall0), .FlushCount(flushc0)
    );

    hazard_control_unit #(.MC_LATENCY(2), .COUNT_WIDTH(16)) dut1 (
        .Clock(Clock), .Reset_n(Reset_n),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegisterRt(ID_EX_RegisterRt),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .IF_ID_UsesRt(IF_ID_UsesRt), .BranchTaken(BranchTaken), .MCStart(MCStart),
        .IF_ID_Signal(sig_o[1]), .PCWrite(pcw_o[1]), .ID_EX_Flush(flush_o[1]),
        .EX_Hold(hold_o[1]), .MCBusy(busy_o[1]),
        .StallCycles(stall1), .FlushCount(flushc1)
    );

    int errors = 0;
    int checks = 0;
    int cycle_no = 0;

    // Model state: remaining MC_BUSY cycles and counter values per instance.
    int m_rem   [2] = '{0, 0};
    int m_stall [2] = '{0, 0};
    int m_flush [2] = '{0, 0};
    int m_lat   [2] = '{4, 2};
    int m_max   [2] = '{15, 65535};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle_no, obs, exp);
        end
    endtask

    task automatic drive(input logic rstn, input logic mr, input logic [4:0] ex_rt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic br, input logic mc);
        Reset_n          = rstn;
        ID_EX_MemRead    = mr;
        ID_EX_RegisterRt = ex_rt;
        IF_ID_RegisterRs = rs;
        IF_ID_RegisterRt = rt;
        IF_ID_UsesRt     = uses;
        BranchTaken      = br;
        MCStart          = mc;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called at posedge+1 with inputs applied: checks, then advances one clock.
    task automatic step();
        int  n_rem [2];
        int  e_sig, e_pcw, e_fl, e_hold, e_busy;
        bit  lu;
        logic [31:0] obs_stall, obs_flush;
        #3;
        lu = ID_EX_MemRead && (ID_EX_RegisterRt != 0) &&
             ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
              (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
        for (int u = 0; u < 2; u++) begin
            n_rem[u] = m_rem[u];
            if (!Reset_n) begin
                m_rem[u] = 0; m_stall[u] = 0; m_flush[u] = 0; n_rem[u] = 0;
                e_sig = 2; e_pcw = 0; e_fl = 1; e_hold = 0; e_busy = 0;
            end else if (m_rem[u] > 0) begin
                e_sig = 1; e_pcw = 0; e_fl = 0; e_hold = 1; e_busy = 1;
                n_rem[u] = m_rem[u] - 1;
            end else if (BranchTaken) begin
                e_sig = 2; e_pcw = 1; e_fl = 1; e_hold = 0; e_busy = 0;
            end else if (MCStart) begin
                e_sig = 1; e_pcw = 0; e_fl = 0; e_hold = 1; e_busy = 0;
                n_rem[u] = m_lat[u] - 2;
            end else if (lu) begin
                e_sig = 1; e_pcw = 0; e_fl = 1; e_hold = 0; e_busy = 0;
            end else begin
                e_sig = 0; e_pcw = 1; e_fl = 0; e_hold = 0; e_busy = 0;
            end
            obs_stall = (u == 0) ? 32'(stall0) : 32'(stall1);
            obs_flush = (u == 0) ? 32'(flushc0) : 32'(flushc1);
            check_eq($sformatf("if_id_signal[%0d]", u), 32'(sig_o[u]), e_sig);
            check_eq($sformatf("pcwrite[%0d]", u), 32'(pcw_o[u]), e_pcw);
            check_eq($sformatf("id_ex_flush[%0d]", u), 32'(flush_o[u]), e_fl);
            check_eq($sformatf("ex_hold[%0d]", u), 32'(hold_o[u]), e_hold);
            check_eq($sformatf("mcbusy[%0d]", u), 32'(busy_o[u]), e_busy);
            check_eq($sformatf("stall_cycles[%0d]", u), obs_stall, m_stall[u]);
            check_eq($sformatf("flush_count[%0d]", u), obs_flush, m_flush[u]);
            if (Reset_n) begin
                if (e_sig == 1 && m_stall[u] < m_max[u]) m_stall[u]++;
                if (e_sig == 2 && m_flush[u] < m_max[u]) m_flush[u]++;
            end
        end
        @(posedge Clock);
        #1;
        cycle_no++;
        for (int u = 0; u < 2; u++) m_rem[u] = n_rem[u];
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        // Reset held for three cycles, then idle.
        repeat (3) step();
        idle();
        repeat (2) step();
        check_eq("idle_stall_zero", 32'(stall0), 0);

        // Load-use on Rs: a single bubble.
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        check_eq("loaduse_stall_one", 32'(stall0), 1);
        // Destination r0 never stalls.
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        // Rt match ignored when Rt is not read.
        drive(1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        check_eq("no_extra_stall", 32'(stall0), 1);

        // Multi-cycle op.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        repeat (4) step();
        check_eq("mc_stall_three", 32'(stall0), 3);
        check_eq("mc_stall_one_lat2", 32'(stall1), 1);

        // Branch beats MCStart and load-use.
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        repeat (2) step();
        check_eq("branch_flush_one", 32'(flushc0), 1);

        // Branch during MC_BUSY is ignored; then reset mid MC_BUSY.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        idle();
        repeat (2) step();
        check_eq("busy_branch_ignored", 32'(flushc0), 1);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        repeat (2) step();
        check_eq("reset_mid_busy_stall", 32'(stall0), 0);

        // Saturation: 20 cycles of continuous load-use.
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (20) step();
        idle();
        check_eq("stall_saturated", 32'(stall0), 15);
        check_eq("stall_wide", 32'(stall1), 20);
        step();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 49) != 0), 1'($urandom), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
